// File: rtl/rr_select_arbiter_8.sv
// Round-robin arbiter for eight sources: drives the 3-bit select of a downstream 8:1 mux
// and registers the selected word behind a valid/ready output handshake.
module rr_select_arbiter_8 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   req,
  input  logic [N-1:0] mux_data,
  input  logic         out_ready,
  output logic [2:0]   select,
  output logic [7:0]   grant,
  output logic         out_valid,
  output logic [N-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     select_q, select_d;
  logic [2:0]     ptr_q, ptr_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;

  logic           win_found;
  logic [2:0]     win_idx;
  logic [2:0]     cand;

  // Scan from ptr upward (mod 8); the first requester met is the winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      select_q    <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = SEL;
      SEL:     state_d = HOLD;
      HOLD:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    select_d    = select_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: if (win_found) select_d = win_idx;
      SEL: begin
        out_data_d  = mux_data;
        out_valid_d = 1'b1;
      end
      HOLD: if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        ptr_d       = select_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state_q == SEL) grant[select_q] = 1'b1;
  end

  assign select    = select_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
